// File: rtl/dcache_controller_if.sv
// Pipeline-side (p1_*) and memory-side (mem_*) signal bundle for dcache_controller.
// The slave modport is the cache; the master modport is the pipeline plus data memory.
interface dcache_controller_if #(
  parameter int LINE_BITS = 256
);
  logic                 p1_MemRead_i;
  logic                 p1_MemWrite_i;
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  // Memory handshake: mem_enable_o is a level request held with a stable
  // mem_addr_o/mem_write_o/mem_data_o until mem_ack_i pulses for one cycle; the
  // transaction completes at the clock edge that samples mem_ack_i high.
  modport slave (
    input  p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Optional hit/miss/writeback counters are compiled in with `define DCACHE_STATS_EN.
module dcache_controller #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 5,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.slave  bus,
  output logic [1:0]          dbg_state_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         stat_hit_o,
  output logic [31:0]         stat_miss_o,
  output logic [31:0]         stat_wb_o
`endif
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORD_BITS = OFFSET_BITS - 2;
  localparam int LINE_BITS = 8 << OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [LINES-1:0]        dirty_q, dirty_d;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0]    data_q [LINES];

  logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
  logic                    mem_enable_q, mem_enable_d;
  logic                    mem_write_q, mem_write_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]    mem_data_q, mem_data_d;

  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [WORD_BITS-1:0]    req_word;
  logic [WORD_BITS+4:0]    word_lsb;
  logic                    req, hit;
  logic [LINE_BITS-1:0]    cur_line;
  logic [31:0]             cur_word;

  logic                    line_we, tag_we;
  logic [INDEX_BITS-1:0]   line_widx;
  logic [LINE_BITS-1:0]    line_wdata;
  logic                    stall, hit_evt, miss_evt, wb_evt;
  logic [31:0]             rdata;
  logic                    unused_addr_lsb;

  assign req_tag   = bus.p1_addr_i[31 -: TAG_BITS];
  assign req_idx   = bus.p1_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_word  = bus.p1_addr_i[2 +: WORD_BITS];
  assign word_lsb  = {req_word, 5'b0};
  assign req       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_line  = data_q[req_idx];
  assign cur_word  = cur_line[word_lsb +: 32];
  assign unused_addr_lsb = ^bus.p1_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_widx    = req_idx;
    line_wdata   = cur_line;
    stall        = 1'b0;
    rdata        = '0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    wb_evt       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          hit_evt = 1'b1;
          // Read data is the pre-write word even when a store hits the same cycle.
          if (bus.p1_MemRead_i) rdata = cur_word;
          if (bus.p1_MemWrite_i) begin
            line_we                      = 1'b1;
            line_wdata[word_lsb +: 32]   = bus.p1_data_i;
            dirty_d[req_idx]             = 1'b1;
          end
        end else if (req) begin
          stall        = 1'b1;
          miss_evt     = 1'b1;
          miss_tag_d   = req_tag;
          miss_idx_d   = req_idx;
          mem_enable_d = 1'b1;
          mem_data_d   = cur_line;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}};
          end else begin
            state_d     = S_REFILL;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
          end
        end
      end

      S_WRITEBACK: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          wb_evt      = 1'b1;
          state_d     = S_REFILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
        end
      end

      S_REFILL: begin
        stall = 1'b1;
        // Uses the latched miss tag/index so a withdrawn request still installs its line.
        if (bus.mem_ack_i) begin
          state_d             = S_IDLE;
          line_we             = 1'b1;
          tag_we              = 1'b1;
          line_widx           = miss_idx_q;
          line_wdata          = bus.mem_data_i;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          mem_enable_d        = 1'b0;
          mem_write_d         = 1'b0;
          mem_addr_d          = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tag/data storage and transaction payload carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (rst_i && line_we) data_q[line_widx] <= line_wdata;
    if (rst_i && tag_we)  tag_q[miss_idx_q] <= miss_tag_q;
    miss_tag_q <= miss_tag_d;
    miss_idx_q <= miss_idx_d;
    mem_data_q <= mem_data_d;
  end

  assign bus.p1_data_o    = rdata;
  assign bus.p1_stall_o   = rst_i ? stall : 1'b0;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign dbg_state_o      = state_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'd0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_evt};
    wb_cnt_d   = wb_cnt_q   + {31'd0, wb_evt};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign stat_hit_o  = hit_cnt_q;
  assign stat_miss_o = miss_cnt_q;
  assign stat_wb_o   = wb_cnt_q;
`endif

endmodule
